// File: rtl/seg_pkg.sv
// seg_pkg: seven-segment glyph constants and BCD-to-segment decoder shared by the counter/mux slice.
package seg_pkg;
    localparam logic [3:0] BCD_MAX   = 4'd9;
    localparam logic [7:0] SEG_0     = 8'b00000011;
    localparam logic [7:0] SEG_1     = 8'b10011111;
    localparam logic [7:0] SEG_2     = 8'b00100101;
    localparam logic [7:0] SEG_3     = 8'b00001101;
    localparam logic [7:0] SEG_4     = 8'b10011001;
    localparam logic [7:0] SEG_5     = 8'b01001001;
    localparam logic [7:0] SEG_6     = 8'b01000001;
    localparam logic [7:0] SEG_7     = 8'b00011111;
    localparam logic [7:0] SEG_8     = 8'b00000001;
    localparam logic [7:0] SEG_9     = 8'b00011001;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    function automatic logic [7:0] bcd_to_seg(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction
endpackage

// File: rtl/seg_counter_mux_if.sv
// seg_counter_mux_if: count controls in, BCD value plus display pins out.
interface seg_counter_mux_if #(parameter int DIGITS = 4);
    logic                  en;
    logic                  dir;
    logic                  clear;
    logic [4*DIGITS-1:0]   count;
    logic                  led;
    logic [7:0]            seg;
    logic [DIGITS-1:0]     an;

    modport master (output en, dir, clear, input count, led, seg, an);
    modport slave  (input en, dir, clear, output count, led, seg, an);
endinterface

// File: rtl/bcd_digit.sv
// bcd_digit: one 0..9 up/down counter stage; carry_out ripples the step into the next digit.
module bcd_digit
    import seg_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       step,
    input  logic       dir,
    output logic [3:0] digit,
    output logic       carry_out
);
    logic [3:0] r_digit;

    always_ff @(posedge clk) begin
        if (reset || clear)
            r_digit <= 4'd0;
        else if (step)
            r_digit <= dir ? (r_digit == BCD_MAX ? 4'd0 : r_digit + 4'd1)
                           : (r_digit == 4'd0 ? BCD_MAX : r_digit - 4'd1);
    end

    assign digit     = r_digit;
    assign carry_out = step & (dir ? r_digit == BCD_MAX : r_digit == 4'd0);
endmodule

// File: rtl/seg_counter_mux.sv
// seg_counter_mux: prescaled multi-digit BCD up/down counter with scanned 7-segment output and wrap LED.
// Define SEG_LEADING_ZERO_BLANK_EN to blank displayed digits above the most significant nonzero digit.
module seg_counter_mux
    import seg_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int DIV_W  = 23,
    parameter int SCAN_W = 16
) (
    input  logic            clk,
    input  logic            reset,
    seg_counter_mux_if.slave bus
);
    localparam int IDX_W = DIGITS > 1 ? $clog2(DIGITS) : 1;

    logic [DIV_W-1:0]  r_div;
    logic [SCAN_W-1:0] r_scan;
    logic [IDX_W-1:0]  r_idx;
    logic              r_led;
    logic [7:0]        r_seg;
    logic [DIGITS-1:0] r_an;

    logic              w_tick;
    logic [DIGITS:0]   w_step;
    logic [3:0]        w_digit [DIGITS];
    logic [DIGITS-1:0] w_blank;
    logic [IDX_W-1:0]  w_idx_next;

    assign w_tick    = &r_div;
    assign w_step[0] = w_tick & bus.en;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .clk       (clk),
            .reset     (reset),
            .clear     (bus.clear),
            .step      (w_step[i]),
            .dir       (bus.dir),
            .digit     (w_digit[i]),
            .carry_out (w_step[i+1])
        );
        assign bus.count[4*i +: 4] = w_digit[i];
    end

`ifdef SEG_LEADING_ZERO_BLANK_EN
    always_comb begin
        logic z;
        w_blank = '0;
        z       = 1'b1;
        for (int k = DIGITS - 1; k > 0; k--) begin
            z          = z & (w_digit[k] == 4'd0);
            w_blank[k] = z;
        end
    end
`else
    assign w_blank = '0;
`endif

    assign w_idx_next = (DIGITS == 1 || r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + 1'b1;

    // an and seg are both loaded from the same r_idx so the pair can never disagree
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div  <= '0;
            r_scan <= '0;
            r_idx  <= '0;
            r_led  <= 1'b0;
            r_an   <= ~DIGITS'(1);
            r_seg  <= SEG_0;
        end else begin
            r_div  <= r_div + 1'b1;
            r_scan <= r_scan + 1'b1;
            if (&r_scan)
                r_idx <= w_idx_next;
            if (w_step[DIGITS] && !bus.clear)
                r_led <= ~r_led;
            r_an   <= ~(DIGITS'(1) << r_idx);
            r_seg  <= w_blank[r_idx] ? SEG_BLANK : bcd_to_seg(w_digit[r_idx]);
        end
    end

    assign bus.led = r_led;
    assign bus.seg = r_seg;
    assign bus.an  = r_an;
endmodule

// File: tb/tb_seg_counter_mux.sv
// tb_seg_counter_mux: directed vectors pushed into an expectation queue, checked by a negedge monitor.
module tb_seg_counter_mux;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    seg_counter_mux_if #(.DIGITS(2)) if2 ();
    seg_counter_mux_if #(.DIGITS(3)) if3 ();

    seg_counter_mux #(.DIGITS(2), .DIV_W(2), .SCAN_W(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (if2)
    );

    seg_counter_mux #(.DIGITS(3), .DIV_W(2), .SCAN_W(1)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (if3)
    );

    typedef struct {
        int         kind;
        string      name;
        logic [7:0] count;
        logic       led;
    } exp_t;

    exp_t q[$];
    int vectors = 0;
    int miscompares = 0;

    // scan-position reference: an shows the index held before each edge
    logic       m_scan, m3_scan;
    logic       m_idx;
    logic [1:0] m3_idx;
    logic [1:0] m_an;
    logic [2:0] m3_an;

    always @(posedge clk) begin
        if (reset) begin
            m_scan <= 1'b0; m_idx <= 1'b0; m_an <= 2'b10;
            m3_scan <= 1'b0; m3_idx <= 2'd0; m3_an <= 3'b110;
        end else begin
            m_an    <= m_idx ? 2'b01 : 2'b10;
            m_scan  <= ~m_scan;
            if (m_scan) m_idx <= ~m_idx;
            m3_an   <= m3_idx == 2'd0 ? 3'b110 : m3_idx == 2'd1 ? 3'b101 : 3'b011;
            m3_scan <= ~m3_scan;
            if (m3_scan) m3_idx <= m3_idx == 2'd2 ? 2'd0 : m3_idx + 2'd1;
        end
    end

    function automatic logic [7:0] glyph(input logic [3:0] d);
        case (d)
            4'd0: return 8'b00000011;
            4'd1: return 8'b10011111;
            4'd2: return 8'b00100101;
            4'd3: return 8'b00001101;
            4'd4: return 8'b10011001;
            4'd5: return 8'b01001001;
            4'd6: return 8'b01000001;
            4'd7: return 8'b00011111;
            4'd8: return 8'b00000001;
            4'd9: return 8'b00011001;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [7:0] exp_seg(input logic [7:0] c, input logic [1:0] an);
        logic [3:0] hi, lo;
        hi = c[7:4];
        lo = c[3:0];
        if (an == 2'b10) return glyph(lo);
`ifdef SEG_LEADING_ZERO_BLANK_EN
        if (hi == 4'd0) return 8'hFF;
`endif
        return glyph(hi);
    endfunction

    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            vectors++;
            if (e.kind == 0) begin
                if (if2.count !== e.count || if2.led !== e.led) begin
                    miscompares++;
                    $display("FAIL %s: count=%h led=%b, required count=%h led=%b",
                             e.name, if2.count, if2.led, e.count, e.led);
                end
            end else if (e.kind == 1) begin
                if (if2.an !== m_an || if2.seg !== exp_seg(e.count, m_an)) begin
                    miscompares++;
                    $display("FAIL %s: an=%b seg=%b, required an=%b seg=%b",
                             e.name, if2.an, if2.seg, m_an, exp_seg(e.count, m_an));
                end
            end else begin
                if (if3.an !== m3_an) begin
                    miscompares++;
                    $display("FAIL %s: an=%b, required an=%b", e.name, if3.an, m3_an);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int kind, input string name, input logic [7:0] c, input logic l);
        exp_t e;
        e.kind = kind; e.name = name; e.count = c; e.led = l;
        q.push_back(e);
    endtask

    initial begin
        reset = 1'b1;
        if2.en = 1'b0; if2.dir = 1'b1; if2.clear = 1'b0;
        if3.en = 1'b0; if3.dir = 1'b0; if3.clear = 1'b0;
        cyc(3);
        push(0, "reset", 8'h00, 1'b0);
        push(1, "reset_disp", 8'h00, 1'b0);
        reset = 1'b0; if2.en = 1'b1;
        cyc(4);   push(0, "first_tick", 8'h01, 1'b0);
        cyc(36);  push(0, "ten_ticks", 8'h10, 1'b0);
        cyc(356); push(0, "at_99", 8'h99, 1'b0);
        cyc(4);   push(0, "wrap_up", 8'h00, 1'b1);
        cyc(400); push(0, "hundred_ticks", 8'h00, 1'b0);
        if2.dir = 1'b0;
        cyc(4);   push(0, "wrap_down", 8'h99, 1'b1);
        cyc(4);   push(0, "decrement", 8'h98, 1'b1);
        if2.dir = 1'b1;
        cyc(4);   push(0, "back_to_99", 8'h99, 1'b1);
        cyc(3);   if2.clear = 1'b1;
        cyc(1);   if2.clear = 1'b0;
        push(0, "clear_on_tick", 8'h00, 1'b1);
        cyc(4);   push(0, "after_clear", 8'h01, 1'b1);
        if2.en = 1'b0;
        cyc(20);  push(0, "hold_en0", 8'h01, 1'b1);
        cyc(1);   if2.clear = 1'b1;
        cyc(1);   if2.clear = 1'b0;
        push(0, "clear_no_tick", 8'h00, 1'b1);
        cyc(2);
        if2.en = 1'b1;
        cyc(148); push(0, "to_37", 8'h37, 1'b1);
        if2.en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc(1); push(1, "scan_37", 8'h37, 1'b1);
        end
        for (int i = 0; i < 6; i++) begin
            cyc(1); push(2, "scan_3digit", 8'h00, 1'b0);
        end
        if2.clear = 1'b1;
        cyc(1);   if2.clear = 1'b0;
        cyc(1);   if2.en = 1'b1;
        cyc(20);  push(0, "to_05", 8'h05, 1'b1);
        if2.en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(1); push(1, "leading_zero", 8'h05, 1'b1);
        end
        if2.en = 1'b1;
        cyc(2);   reset = 1'b1;
        cyc(1);
        push(0, "mid_reset", 8'h00, 1'b0);
        push(1, "mid_reset_disp", 8'h00, 1'b0);
        reset = 1'b0;
        cyc(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
